// File: rtl/door_lock_ctrl.sv
// door_lock_ctrl: N_CH independent password lock channels with lockout and intrusion flag.
// Define AUTO_RELOCK_EN to build the closed-door auto relock timer.
module door_lock_ctrl #(
  parameter int              N_CH           = 4,
  parameter int              PW_W           = 17,
  parameter logic [PW_W-1:0] DEFAULT_PW     = 17'd45675,
  parameter int              MAX_FAIL       = 3,
  parameter int              LOCKOUT_CYCLES = 16,
  parameter int              RELOCK_CYCLES  = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_CH-1:0]      enter,
  input  logic [N_CH-1:0]      rs_button,
  input  logic [N_CH-1:0]      lock_button,
  input  logic [N_CH-1:0]      door_state,
  input  logic [N_CH*PW_W-1:0] in_password,
  input  logic [N_CH*PW_W-1:0] chg_password,
  output logic [N_CH-1:0]      unlock,
  output logic [N_CH-1:0]      lockout,
  output logic [N_CH-1:0]      pw_changed,
  output logic [N_CH-1:0]      intrusion
);

  localparam int FW    = $clog2(MAX_FAIL + 1);
  localparam int T_MAX = (LOCKOUT_CYCLES > RELOCK_CYCLES) ?
                         LOCKOUT_CYCLES : RELOCK_CYCLES;
  localparam int TW    = $clog2(T_MAX + 1);

  localparam logic [FW-1:0] FAIL_LIM = FW'(MAX_FAIL);
  localparam logic [FW-1:0] F_ONE    = FW'(1);
  localparam logic [TW-1:0] LO_LOAD  = TW'(LOCKOUT_CYCLES);
  localparam logic [TW-1:0] T_ONE    = TW'(1);
`ifdef AUTO_RELOCK_EN
  localparam logic [TW-1:0] RL_LOAD  = TW'(RELOCK_CYCLES);
`endif

  typedef enum logic [1:0] {
    LOCKED   = 2'd0,
    UNLOCKED = 2'd1,
    LOCKOUT  = 2'd2
  } state_t;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    state_t          st_q, st_d;
    logic [PW_W-1:0] pw_q, pw_d;
    logic [FW-1:0]   fc_q, fc_d;
    logic [TW-1:0]   tm_q, tm_d;
    logic            en_q;
    logic            chg_q, chg_d;
    logic            intr_q, intr_d;
    logic            ev, match, clr;
    logic            armed;

    assign ev    = enter[i] & ~en_q;
    assign match = (in_password[i*PW_W +: PW_W] == pw_q);
    assign armed = (st_q != UNLOCKED);

    // next-state, password store, fail counter and timer
    always_comb begin
      st_d  = st_q;
      pw_d  = pw_q;
      fc_d  = fc_q;
      tm_d  = tm_q;
      chg_d = 1'b0;
      clr   = 1'b0;
      unique case (st_q)
        LOCKED: begin
          if (ev) begin
            if (match && rs_button[i]) begin
              pw_d  = chg_password[i*PW_W +: PW_W];
              chg_d = 1'b1;
              fc_d  = '0;
            end else if (match) begin
              st_d = UNLOCKED;
              fc_d = '0;
              clr  = 1'b1;
`ifdef AUTO_RELOCK_EN
              tm_d = RL_LOAD;
`endif
            end else if (fc_q + F_ONE == FAIL_LIM) begin
              st_d = LOCKOUT;
              tm_d = LO_LOAD;
              fc_d = '0;
            end else begin
              fc_d = fc_q + F_ONE;
            end
          end
        end
        UNLOCKED: begin
          if (lock_button[i]) begin
            st_d = LOCKED;
`ifdef AUTO_RELOCK_EN
          end else if (door_state[i]) begin
            tm_d = RL_LOAD;
          end else if (tm_q == T_ONE) begin
            st_d = LOCKED;
            tm_d = '0;
          end else begin
            tm_d = tm_q - T_ONE;
`endif
          end
        end
        LOCKOUT: begin
          if (tm_q == T_ONE) begin
            st_d = LOCKED;
            tm_d = '0;
          end else begin
            tm_d = tm_q - T_ONE;
          end
        end
        default: begin
          st_d = LOCKED;
        end
      endcase
      intr_d = (intr_q | (door_state[i] & armed)) & ~clr;
    end

    // channel state registers
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        st_q   <= LOCKED;
        pw_q   <= DEFAULT_PW;
        fc_q   <= '0;
        tm_q   <= '0;
        en_q   <= 1'b0;
        chg_q  <= 1'b0;
        intr_q <= 1'b0;
      end else begin
        st_q   <= st_d;
        pw_q   <= pw_d;
        fc_q   <= fc_d;
        tm_q   <= tm_d;
        en_q   <= enter[i];
        chg_q  <= chg_d;
        intr_q <= intr_d;
      end
    end

    assign unlock[i]     = (st_q == UNLOCKED);
    assign lockout[i]    = (st_q == LOCKOUT);
    assign pw_changed[i] = chg_q;
    assign intrusion[i]  = intr_q;
  end

endmodule
